// File: rtl/axis_ifmaps_line_fifo.sv
// Packs AXI-Stream beats into PIX_BITS*MAC_NUM-bit ifmap lines and buffers the
// completed lines in a small first-word-fall-through FIFO that feeds the MAC array.
module axis_ifmaps_line_fifo #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int PIX_BITS             = 5,
    parameter int MAC_NUM              = 256,
    parameter int FIFO_DEPTH           = 4,
    localparam int LINE_BITS           = PIX_BITS * MAC_NUM,
    localparam int LVL_W               = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [LINE_BITS-1:0]            ifmaps_out,
    output logic                            ifmaps_last,
    output logic                            ifmaps_valid,
    input  logic                            mac_ready,
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic [LVL_W-1:0]                fifo_level,
    output logic                            err_short
);

    localparam int TW       = C_S_AXIS_TDATA_WIDTH;
    localparam int BEATS    = (LINE_BITS + TW - 1) / TW;
    localparam int PAD_BITS = BEATS * TW;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BCW      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    // Entries are kept beat-aligned; bits above LINE_BITS never reach the output.
    logic [PAD_BITS-1:0] line_mem [FIFO_DEPTH];
    logic                last_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [BCW-1:0]      beat_cnt;
    logic [LVL_W-1:0]    level;
    logic                err_short_q;

    logic                accept;
    logic                commit;
    logic                pop;
    logic [PAD_BITS-1:0] wr_line;
    logic [PAD_BITS-1:0] head_line;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign fifo_full     = (level == DEPTH_LVL);
    assign fifo_empty    = (level == '0);
    assign fifo_level    = level;
    assign err_short     = err_short_q;
    assign s_axis_tready = ~fifo_full;
    assign ifmaps_valid  = ~fifo_empty;

    assign accept = s_axis_tvalid & s_axis_tready;
    assign commit = accept & ((beat_cnt == LAST_BEAT) | s_axis_tlast);
    assign pop    = ifmaps_valid & mac_ready;

    // The first beat of a line starts from a zeroed entry so short lines pad with 0.
    always_comb begin
        wr_line = (beat_cnt == '0) ? '0 : line_mem[wr_ptr];
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == BCW'(b)) begin
                wr_line[b*TW +: TW] = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !clear) begin
            line_mem[wr_ptr] <= wr_line;
            if (commit) begin
                last_mem[wr_ptr] <= s_axis_tlast;
            end
        end
    end

    // Head is forced to zero while empty so the output never exposes stale or X memory.
    assign head_line   = line_mem[rd_ptr];
    assign ifmaps_out  = fifo_empty ? '0 : head_line[LINE_BITS-1:0];
    assign ifmaps_last = ~fifo_empty & last_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            level       <= '0;
            err_short_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            beat_cnt    <= '0;
            level       <= '0;
            err_short_q <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= commit ? '0 : beat_cnt + 1'b1;
            end
            if (commit) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (commit && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !commit) begin
                level <= level - 1'b1;
            end
            if (commit && s_axis_tlast && (beat_cnt != LAST_BEAT)) begin
                err_short_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_ifmaps_line_fifo.sv
// Bench for axis_ifmaps_line_fifo: queue-based line model checked every cycle,
// directed scenarios with literal expectations, and a small-geometry instance.
module tb_axis_ifmaps_line_fifo;

    localparam int W       = 32;
    localparam int LB      = 1280;
    localparam int BEATS   = 40;
    localparam int DEPTH   = 4;
    localparam int LB_B    = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [W-1:0]  tdata = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          mac_ready = 1'b0;
    logic          tready;
    logic [LB-1:0] ifo;
    logic          ifl, ifv, fe, ff, err;
    logic [2:0]    lvl;

    logic [W-1:0]    tdata_b = '0;
    logic            tvalid_b = 1'b0;
    logic            tlast_b = 1'b0;
    logic            mac_ready_b = 1'b0;
    logic            tready_b;
    logic [LB_B-1:0] ifo_b;
    logic            ifl_b, ifv_b, fe_b, ff_b, err_b;
    logic [1:0]      lvl_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    axis_ifmaps_line_fifo #(.C_S_AXIS_TDATA_WIDTH(32), .PIX_BITS(5), .MAC_NUM(256), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast), .s_axis_tready(tready),
        .ifmaps_out(ifo), .ifmaps_last(ifl), .ifmaps_valid(ifv), .mac_ready(mac_ready),
        .fifo_empty(fe), .fifo_full(ff), .fifo_level(lvl), .err_short(err)
    );

    axis_ifmaps_line_fifo #(.C_S_AXIS_TDATA_WIDTH(32), .PIX_BITS(8), .MAC_NUM(16), .FIFO_DEPTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_axis_tdata(tdata_b), .s_axis_tvalid(tvalid_b), .s_axis_tlast(tlast_b), .s_axis_tready(tready_b),
        .ifmaps_out(ifo_b), .ifmaps_last(ifl_b), .ifmaps_valid(ifv_b), .mac_ready(mac_ready_b),
        .fifo_empty(fe_b), .fifo_full(ff_b), .fifo_level(lvl_b), .err_short(err_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: committed lines as a queue, the open line as a list of beats.
    logic [LB-1:0] mq_line[$];
    bit            mq_last[$];
    logic [W-1:0]  m_beats[$];
    bit            m_err = 1'b0;
    int            dut_pops = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_tready", tready, 1);
                chk("rst_valid", ifv, 0);
                chk("rst_level", lvl, 0);
                chk("rst_err", err, 0);
                chk("rst_empty", fe, 1);
                chk("rst_full", ff, 0);
                chk("rst_last", ifl, 0);
                chk("rst_out_zero", |ifo, 0);
                mq_line.delete(); mq_last.delete(); m_beats.delete(); m_err = 1'b0;
            end else begin
                logic [LB-1:0] exp_out;
                int            sz;
                int            d;
                bit            rdy;
                bit            pp;
                sz = mq_line.size();
                exp_out = (sz > 0) ? mq_line[0] : '0;
                chk("level", lvl, sz);
                chk("full", ff, sz == DEPTH);
                chk("empty", fe, sz == 0);
                chk("tready", tready, sz < DEPTH);
                chk("valid", ifv, sz > 0);
                chk("last", ifl, (sz > 0) ? mq_last[0] : 1'b0);
                chk("err_short", err, m_err);
                d = -1;
                for (int i = 0; i < BEATS; i++) begin
                    if (d < 0 && ifo[i*W +: W] !== exp_out[i*W +: W]) d = i;
                end
                total++;
                if (d >= 0) begin
                    bad++;
                    $display("FAIL ifmaps_out word %0d: got %0h expected %0h", d, ifo[d*W +: W], exp_out[d*W +: W]);
                end
                if (ifv && mac_ready) dut_pops++;
                // Advance the model with the inputs that the next rising edge will sample.
                if (clear) begin
                    mq_line.delete(); mq_last.delete(); m_beats.delete(); m_err = 1'b0;
                end else begin
                    rdy = (sz < DEPTH);
                    pp  = (sz > 0) && mac_ready;
                    if (pp) begin
                        void'(mq_line.pop_front());
                        void'(mq_last.pop_front());
                    end
                    if (tvalid && rdy) begin
                        m_beats.push_back(tdata);
                        if (m_beats.size() == BEATS || tlast) begin
                            logic [LB-1:0] ln;
                            ln = '0;
                            for (int i = 0; i < m_beats.size(); i++) ln[i*W +: W] = m_beats[i];
                            if (m_beats.size() < BEATS) m_err = 1'b1;
                            mq_line.push_back(ln);
                            mq_last.push_back(tlast);
                            m_beats.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic l);
        int  n;
        bit  r;
        tvalid = 1'b1; tdata = d; tlast = l;
        n = 0;
        do begin
            @(negedge clk);
            r = tready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 2000);
        if (!r) begin
            bad++;
            $display("FAIL send_timeout: got tready=0 expected acceptance within 2000 cycles");
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    task automatic send_b(input logic [W-1:0] d);
        int  n;
        bit  r;
        tvalid_b = 1'b1; tdata_b = d;
        n = 0;
        do begin
            @(negedge clk);
            r = tready_b;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) begin
            bad++;
            $display("FAIL send_b_timeout: got tready=0 expected acceptance within 200 cycles");
        end
        tvalid_b = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int max_lvl;
        int p0;
        bit stall;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("t1_tready", tready, 1);
        chk("t1_valid", ifv, 0);
        chk("t1_level", lvl, 0);
        chk("t1_err", err, 0);

        for (int i = 0; i < 10; i++) send(32'h5500 + i, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t1_mid_tready", tready, 1);
        chk("t1_mid_level", lvl, 0);
        tick();
        rst_n = 1'b1;
        tick();

        mac_ready = 1'b0;
        for (int i = 0; i < 40; i++) send(i, 1'b0);
        chk("t2_valid", ifv, 1);
        chk("t2_lo", ifo[31:0], 0);
        chk("t2_hi", ifo[1279:1248], 39);
        chk("t2_last", ifl, 0);
        chk("t2_level", lvl, 1);

        do_clear();
        for (int i = 0; i < 160; i++) send(32'h1000 + i, 1'b0);
        chk("t3_level", lvl, 4);
        chk("t3_full", ff, 1);
        chk("t3_tready", tready, 0);
        chk("t3_head_lo", ifo[31:0], 32'h1000);
        tvalid = 1'b1; tdata = 32'hABCD0000;
        repeat (3) tick();
        chk("t3_held_level", lvl, 4);
        chk("t3_held_tready", tready, 0);
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        chk("t3_pop_level", lvl, 3);
        chk("t3_pop_tready", tready, 1);
        chk("t3_new_head", ifo[31:0], 32'h1000 + 40);
        send(32'hABCD0000, 1'b0);
        for (int i = 1; i < 40; i++) send(32'hABCD0000 + i, 1'b0);
        chk("t3_refill", lvl, 4);
        mac_ready = 1'b1;
        repeat (6) tick();
        chk("t3_drained", lvl, 0);

        max_lvl = 0;
        p0 = dut_pops;
        for (int i = 0; i < 400; i++) begin
            send($urandom, 1'b0);
            if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
        end
        repeat (3) tick();
        chk("t4_max_level_le1", max_lvl <= 1, 1);
        chk("t4_pops", dut_pops - p0, 10);
        mac_ready = 1'b0;

        for (int i = 0; i < 6; i++) send(32'hFFFFFFFF, i == 5);
        chk("t5_ones", &ifo[191:0], 1);
        chk("t5_pad_zero", |ifo[LB-1:192], 0);
        chk("t5_last", ifl, 1);
        chk("t5_err", err, 1);
        for (int i = 0; i < 40; i++) send(100 + i, 1'b0);
        chk("t5_level", lvl, 2);
        mac_ready = 1'b1;
        tick();
        mac_ready = 1'b0;
        chk("t5_next_lo", ifo[31:0], 100);
        chk("t5_next_hi", ifo[1279:1248], 139);
        chk("t5_next_last", ifl, 0);
        chk("t5_err_sticky", err, 1);

        for (int i = 0; i < 39; i++) send(32'h7700 + i, 1'b0);
        tvalid = 1'b1; tdata = 32'h77FF; mac_ready = 1'b1; clear = 1'b1;
        tick();
        tvalid = 1'b0; mac_ready = 1'b0; clear = 1'b0;
        chk("t6_level", lvl, 0);
        chk("t6_empty", fe, 1);
        chk("t6_err", err, 0);
        chk("t6_out_zero", |ifo, 0);
        for (int i = 0; i < 40; i++) send(200 + i, 1'b0);
        chk("t6_restart_lo", ifo[31:0], 200);
        chk("t6_restart_hi", ifo[1279:1248], 239);
        chk("t6_restart_level", lvl, 1);

        stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) stall = ($urandom_range(0, 2) == 0);
            tvalid    = ($urandom_range(0, 3) != 0);
            tdata     = $urandom;
            tlast     = ($urandom_range(0, 59) == 0);
            mac_ready = stall ? 1'b0 : ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 499) == 0);
            tick();
        end
        tvalid = 1'b0; tlast = 1'b0; clear = 1'b0; mac_ready = 1'b1;
        repeat (6) tick();
        mac_ready = 1'b0;
        do_clear();

        for (int l = 0; l < 3; l++)
            for (int b = 0; b < 4; b++) send_b(l * 16 + b);
        chk("t6b_level", lvl_b, 3);
        chk("t6b_full", ff_b, 1);
        chk("t6b_tready", tready_b, 0);
        chk("t6b_head0_lo", ifo_b[31:0], 0);
        chk("t6b_head0_hi", ifo_b[127:96], 3);
        mac_ready_b = 1'b1;
        tick();
        mac_ready_b = 1'b0;
        chk("t6b_pop_level", lvl_b, 2);
        for (int b = 0; b < 4; b++) send_b(48 + b);
        chk("t6b_wrap_level", lvl_b, 3);
        for (int l = 1; l < 4; l++) begin
            chk("t6b_order_lo", ifo_b[31:0], l * 16);
            chk("t6b_order_hi", ifo_b[127:96], l * 16 + 3);
            mac_ready_b = 1'b1;
            tick();
            mac_ready_b = 1'b0;
        end
        chk("t6b_empty", fe_b, 1);
        chk("t6b_err", err_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
